// File: rtl/umi_req_encode.sv
// ---------------------------------------------------------------------------
// umi_req_encode
//
// Host-side UMI request transmitter. Takes one transaction per valid/ready
// handshake on the req_* side, builds the UMI command word for it and emits
// it as a registered packet on the umi_out_* side. Non-posted requests
// (read, write, atomic, rdma) consume a credit. Read/write responses on the
// return path give the credit back. Once MAXOUT credits are in use, further
// non-posted requests are held off.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   req_valid/ready   host request handshake
//   req_type          0=read 1=write 2=posted 3=atomic 4=rdma 5=link 6,7=illegal
//   req_atype         atomic sub-op, placed in cmd[15:8] for atomics
//   req_len           burst length, placed in cmd[15:8] for non-atomics
//   req_size          log2 transfer size, placed in cmd[19:16]
//   req_dstaddr       destination address
//   req_srcaddr       source / return address
//   req_data          write data
//   umi_out_*         registered outgoing packet with valid/ready
//   resp_valid/cmd    response seen on the return path (single-cycle)
//   outstanding       number of non-posted requests awaiting a response
//   idle              no packet pending and nothing outstanding
//   err_type          sticky: an illegal req_type was accepted
//   err_resp          sticky: a credit-releasing response arrived at zero
// ---------------------------------------------------------------------------
module umi_req_encode #(
  parameter int CW     = 32,
  parameter int AW     = 64,
  parameter int DW     = 256,
  parameter int MAXOUT = 8,
  localparam int OW    = $clog2(MAXOUT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  // host request side
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_type,
  input  logic [7:0]    req_atype,
  input  logic [7:0]    req_len,
  input  logic [3:0]    req_size,
  input  logic [AW-1:0] req_dstaddr,
  input  logic [AW-1:0] req_srcaddr,
  input  logic [DW-1:0] req_data,
  // outgoing packet
  output logic          umi_out_valid,
  input  logic          umi_out_ready,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  // return path
  input  logic          resp_valid,
  input  logic [CW-1:0] resp_cmd,
  // status
  output logic [OW-1:0] outstanding,
  output logic          idle,
  output logic          err_type,
  output logic          err_resp
);

  // UMI opcode values shared with the device-side command decoder.
  localparam logic [7:0] UMI_REQ_POSTED = 8'h01;
  localparam logic [7:0] UMI_REQ_READ   = 8'h02;
  localparam logic [7:0] UMI_REQ_WRITE  = 8'h03;
  localparam logic [7:0] UMI_REQ_ATOMIC = 8'h04;
  localparam logic [7:0] UMI_REQ_RDMA   = 8'h06;
  localparam logic [7:0] UMI_REQ_LINK   = 8'h0E;
  localparam logic [7:0] UMI_RESP_READ  = 8'h08;
  localparam logic [7:0] UMI_RESP_WRITE = 8'h09;
  localparam logic [7:0] UMI_RESP_LINK  = 8'h19;

  localparam logic [OW-1:0] MAXOUT_W = OW'(MAXOUT);

  // request type encoding
  typedef enum logic [2:0] {
    TYPE_READ   = 3'd0,
    TYPE_WRITE  = 3'd1,
    TYPE_POSTED = 3'd2,
    TYPE_ATOMIC = 3'd3,
    TYPE_RDMA   = 3'd4,
    TYPE_LINK   = 3'd5
  } req_type_e;

  logic          w_np;
  logic          w_legal;
  logic          w_isAtomic;
  logic          w_isLink;
  logic [7:0]    w_opcode;
  logic [CW-1:0] w_cmd;
  logic          w_outFree;
  logic          w_creditOk;
  logic          w_accept;
  logic          w_acceptLegal;
  logic          w_acceptIllegal;
  logic          w_incr;
  logic          w_release;
  logic          w_atZero;

  logic          r_valid;
  logic [CW-1:0] r_cmd;
  logic [AW-1:0] r_dstaddr;
  logic [AW-1:0] r_srcaddr;
  logic [DW-1:0] r_data;
  logic [OW-1:0] r_outstanding;
  logic          r_errType;
  logic          r_errResp;

  // Classify the incoming request type: opcode, whether it needs a credit,
  // and whether it produces a packet at all.
  always_comb begin
    w_opcode   = 8'h00;
    w_np       = 1'b0;
    w_legal    = 1'b1;
    w_isAtomic = 1'b0;
    w_isLink   = 1'b0;
    case (req_type)
      TYPE_READ: begin
        w_opcode = UMI_REQ_READ;
        w_np     = 1'b1;
      end
      TYPE_WRITE: begin
        w_opcode = UMI_REQ_WRITE;
        w_np     = 1'b1;
      end
      TYPE_POSTED: begin
        w_opcode = UMI_REQ_POSTED;
      end
      TYPE_ATOMIC: begin
        w_opcode   = UMI_REQ_ATOMIC;
        w_np       = 1'b1;
        w_isAtomic = 1'b1;
      end
      TYPE_RDMA: begin
        w_opcode = UMI_REQ_RDMA;
        w_np     = 1'b1;
      end
      TYPE_LINK: begin
        w_opcode = UMI_REQ_LINK;
        w_isLink = 1'b1;
      end
      default: begin
        // Illegal types are accepted like posted requests and then dropped.
        w_legal = 1'b0;
      end
    endcase
  end

  // Build the command word. For atomics the sub-op replaces the length
  // field. Link packets carry no length.
  always_comb begin
    w_cmd        = '0;
    w_cmd[7:0]   = w_opcode;
    w_cmd[19:16] = req_size;
    if (w_isAtomic) begin
      w_cmd[15:8] = req_atype;
    end else if (w_isLink) begin
      w_cmd[15:8] = 8'h00;
    end else begin
      w_cmd[15:8] = req_len;
    end
  end

  // The output slot is free when it is empty or is draining this cycle, which
  // allows one accept per cycle at full rate. The credit gate only applies to
  // non-posted requests. req_valid is deliberately not part of req_ready.
  assign w_outFree  = ~r_valid | umi_out_ready;
  assign w_creditOk = (r_outstanding < MAXOUT_W);
  assign req_ready  = w_outFree & (~w_np | w_creditOk);

  assign w_accept        = req_valid & req_ready;
  assign w_acceptLegal   = w_accept & w_legal;
  assign w_acceptIllegal = w_accept & ~w_legal;
  assign w_incr          = w_accept & w_np;

  // Read and write responses share their low nibble with other response
  // codes. The link response aliases one of them, so it is excluded by a
  // full byte compare.
  assign w_release = resp_valid
                   & ((resp_cmd[3:0] == UMI_RESP_READ[3:0]) |
                      (resp_cmd[3:0] == UMI_RESP_WRITE[3:0]))
                   & (resp_cmd[7:0] != UMI_RESP_LINK);

  assign w_atZero = (r_outstanding == '0);

  // Packet valid: a new legal accept always refills the slot. Otherwise the
  // slot empties when downstream takes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
    end else if (w_acceptLegal) begin
      r_valid <= 1'b1;
    end else if (umi_out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload registers have no reset. They are only meaningful while r_valid
  // is set, and they only load on an accept, so they hold steady under
  // backpressure.
  always_ff @(posedge clk) begin
    if (w_acceptLegal) begin
      r_cmd     <= w_cmd;
      r_dstaddr <= req_dstaddr;
      r_srcaddr <= req_srcaddr;
      r_data    <= req_data;
    end
  end

  // Credit counter. A release at zero is ignored, so the counter never
  // wraps, and it still counts a simultaneous accept. The ready gate keeps
  // the counter from going past MAXOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_outstanding <= '0;
    end else begin
      case ({w_incr, w_release & ~w_atZero})
        2'b10:   r_outstanding <= r_outstanding + OW'(1);
        2'b01:   r_outstanding <= r_outstanding - OW'(1);
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // Sticky error flags. Only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_errType <= 1'b0;
      r_errResp <= 1'b0;
    end else begin
      if (w_acceptIllegal) begin
        r_errType <= 1'b1;
      end
      if (w_release && w_atZero) begin
        r_errResp <= 1'b1;
      end
    end
  end

  assign umi_out_valid   = r_valid;
  assign umi_out_cmd     = r_cmd;
  assign umi_out_dstaddr = r_dstaddr;
  assign umi_out_srcaddr = r_srcaddr;
  assign umi_out_data    = r_data;
  assign outstanding     = r_outstanding;
  assign idle            = ~r_valid & w_atZero;
  assign err_type        = r_errType;
  assign err_resp        = r_errResp;

endmodule

// File: doc/umi_req_encode.md
Name: umi_req_encode

Overview:
- Host-side UMI request transmitter: accepts transaction fields, encodes the UMI command word, and emits one registered request packet per accepted transaction over valid/ready.
- Counterpart of the command decoder at the device end; uses the opcode constants in umi_messages.vh.
- Tracks outstanding non-posted requests (read, write, atomic, rdma). Matching responses on the return path release credits, and an outstanding limit applies backpressure.

Parameters:
- CW, 32, command word width (>=32)
- AW, 64, address width
- DW, 256, data width
- MAXOUT, 8, max outstanding non-posted requests (1..255); counter width OW = $clog2(MAXOUT+1)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid  input  1  host request valid
- req_ready  output  1  host request accepted when valid&ready
- req_type  input  3  0=read 1=write 2=posted 3=atomic 4=rdma 5=link 6,7=illegal
- req_atype  input  8  atomic sub-op (UMI_REQ_ATOMIC* value)
- req_len  input  8  burst length field
- req_size  input  4  log2 transfer size
- req_dstaddr  input  AW  destination address
- req_srcaddr  input  AW  source/return address
- req_data  input  DW  write data
- umi_out_valid  output  1  packet valid
- umi_out_ready  input  1  downstream ready
- umi_out_cmd  output  CW  encoded command
- umi_out_dstaddr  output  AW  registered dstaddr
- umi_out_srcaddr  output  AW  registered srcaddr
- umi_out_data  output  DW  registered data
- resp_valid  input  1  response accepted on return path (single-cycle qualifier)
- resp_cmd  input  CW  command of that response
- outstanding  output  OW  current outstanding count
- idle  output  1  ~umi_out_valid & (outstanding==0)
- err_type  output  1  sticky: illegal req_type accepted
- err_resp  output  1  sticky: credit-releasing response with outstanding==0

Behaviour:
- Reset (sync, clk edge with reset=1): umi_out_valid=0, outstanding=0, err_type=0, err_resp=0. Packet payload registers are don't-care. This takes priority over every other event in the same cycle.
- Non-posted request (np): req_type in {0,3,4}; write (1) also counts. Posted (2) and link (5) never consume credit.
- req_ready = (~umi_out_valid | umi_out_ready) & (~np | outstanding<MAXOUT). This is combinational; req_ready must not depend on req_valid.
- Accept (req_valid&req_ready): the output register loads the next cycle, giving 1-cycle latency. Fields do not change while umi_out_valid & ~umi_out_ready.
- Command encoding:
  - cmd[7:0] = UMI_REQ_READ/WRITE/POSTED/ATOMIC/RDMA/LINK per type.
  - cmd[15:8] = req_atype if atomic, else req_len.
  - cmd[19:16] = req_size.
  - cmd[CW-1:20] = 0.
- Link: cmd[15:8]=0, and data/addresses pass through.
- Illegal type: accepted (req_ready follows the posted rule), dropped with no packet, err_type set.
- umi_out_valid: set on a legal accept. It clears on umi_out_ready only if no new accept occurs that cycle. Back-to-back accepts at full throughput are required when umi_out_ready=1.
- Credit release: resp_valid & resp_cmd[3:0] in {UMI_RESP_READ[3:0], UMI_RESP_WRITE[3:0]}, excluding UMI_RESP_LINK (full 8-bit compare). Other responses are ignored.
- Counter: +1 on np accept, -1 on release. Simultaneous increment and decrement gives a net 0. It can never exceed MAXOUT because the ready gate prevents it.
- Release at 0: the counter stays 0 (no wrap) and err_resp is set. If an np accept happens in the same cycle, the counter = 1 and err_resp is still set.
- Sticky errors clear only on reset.

Test Plan:
- Reset, then a single write: type=1, size=3, len=0, dstaddr=0x1000, umi_out_ready=1. Required: packet the next cycle with cmd[7:0]=UMI_REQ_WRITE and cmd[19:16]=3; outstanding=1; idle=0.
- Backpressure: hold umi_out_ready=0 for 5 cycles after a read is issued. Required: cmd/addr/data stay stable, req_ready=0, and the packet transfers on the first ready cycle.
- Credit limit, MAXOUT=8: 8 reads with no responses. Required: outstanding=8, req_ready=0 for a 9th read, while a posted request is still accepted and emitted. One UMI_RESP_READ then gives outstanding=7, and the read is accepted the following cycle.
- Simultaneous: np accept and read response in the same cycle with outstanding=4. Required: stays 4. Atomic type=3 with atype=UMI_REQ_ATOMICADD. Required: cmd[15:8]=UMI_REQ_ATOMICADD.
- Errors: type=6 accepted. Required: no umi_out_valid, err_type=1. UMI_RESP_WRITE at outstanding=0. Required: err_resp=1, outstanding=0. A UMI_RESP_LINK response. Required: counter unchanged.
- Mid-operation reset: assert reset while umi_out_valid=1 and outstanding=3. Required: the next cycle has umi_out_valid=0, outstanding=0, errors cleared, idle=1.
